im_arbiter: RTL and testbench

- Owns the single port of the instruction memory and shares it between two requesters: the fetch path, which reads, and the program loader, which writes.
- Sequences the boot phase, when the loader has exclusive access, and the run phase, when fetch has priority and loader writes are starvation-bounded.
- Tracks the one-cycle synchronous read latency and applies flushes to in-flight fetch responses.

---
 rtl/im_arbiter.sv | 110 +++++++++++
 tb/tb_im_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/im_arbiter.sv
// Instruction-memory port arbiter: boot-time exclusive loader access, run-time
// fetch priority with a starvation bound on loader writes, and read-response tracking.
//
// state | meaning
// BOOT  | loader owns the memory port, fetch held off
// RUN   | fetch has priority, loader forced through after MAX_WAIT denials
// DRAIN | no grants; lets the last fetch response retire before reload
module im_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int BYTES    = 4,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_fetch_req,
  input  logic [ADDR_W-1:0] i_fetch_addr,
  output logic              o_fetch_gnt,
  output logic              o_fetch_rvalid,
  output logic [DATA_W-1:0] o_fetch_rdata,
  input  logic              i_flush,
  input  logic              i_ld_req,
  input  logic [ADDR_W-1:0] i_ld_addr,
  input  logic [DATA_W-1:0] i_ld_wdata,
  input  logic [BYTES-1:0]  i_ld_be,
  output logic              o_ld_gnt,
  input  logic              i_ld_start,
  input  logic              i_ld_done,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic [BYTES-1:0]  o_mem_wen,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_boot_busy
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  typedef enum logic [1:0] {BOOT, RUN, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              pend_q, pend_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BOOT;
      wait_q  <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      pend_q  <= pend_d;
    end
  end

  // Grants are forced low while rst is high, even though state already reads BOOT.
  always_comb begin
    state_d     = state_q;
    o_fetch_gnt = 1'b0;
    o_ld_gnt    = 1'b0;
    if (!rst) begin
      case (state_q)
        BOOT: begin
          o_ld_gnt = i_ld_req;
          if (i_ld_done) state_d = RUN;
        end
        RUN: begin
          if (i_fetch_req && i_ld_req) begin
            if (wait_q == WAIT_MAX) o_ld_gnt    = 1'b1;
            else                    o_fetch_gnt = 1'b1;
          end else begin
            o_fetch_gnt = i_fetch_req;
            o_ld_gnt    = i_ld_req;
          end
          if (i_ld_start) state_d = DRAIN;
        end
        // No fetch can fire here, so the outstanding read always retires this cycle.
        DRAIN:   state_d = BOOT;
        default: state_d = BOOT;
      endcase
    end
  end

  always_comb begin
    wait_d = '0;
    if (i_ld_req && !o_ld_gnt)
      wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + 1'b1;
  end

  assign pend_d = o_fetch_gnt & i_fetch_req & ~i_flush;

  always_comb begin
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_wen   = '0;
    if (o_ld_gnt) begin
      o_mem_addr  = i_ld_addr;
      o_mem_wdata = i_ld_wdata;
      o_mem_wen   = i_ld_be;
    end else if (o_fetch_gnt) begin
      o_mem_addr  = i_fetch_addr;
    end
  end

  assign o_fetch_rvalid = pend_q & ~i_flush;
  assign o_fetch_rdata  = o_fetch_rvalid ? i_mem_rdata : '0;
  assign o_boot_busy    = (state_q != RUN);

endmodule

// File: tb/tb_im_arbiter.sv
// Directed bench for im_arbiter with a byte-writable synchronous memory model.
module tb_im_arbiter;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int BYTES  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              fetch_req, fetch_gnt, fetch_rvalid, flush;
  logic [ADDR_W-1:0] fetch_addr, ld_addr, mem_addr;
  logic [DATA_W-1:0] fetch_rdata, ld_wdata, mem_wdata, mem_rdata;
  logic              ld_req, ld_gnt, ld_start, ld_done, boot_busy;
  logic [BYTES-1:0]  ld_be, mem_wen;

  logic [DATA_W-1:0] mem [2**ADDR_W];
  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  im_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BYTES(BYTES), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .i_fetch_req(fetch_req), .i_fetch_addr(fetch_addr), .o_fetch_gnt(fetch_gnt),
    .o_fetch_rvalid(fetch_rvalid), .o_fetch_rdata(fetch_rdata), .i_flush(flush),
    .i_ld_req(ld_req), .i_ld_addr(ld_addr), .i_ld_wdata(ld_wdata), .i_ld_be(ld_be),
    .o_ld_gnt(ld_gnt), .i_ld_start(ld_start), .i_ld_done(ld_done),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_wen(mem_wen),
    .i_mem_rdata(mem_rdata), .o_boot_busy(boot_busy)
  );

  initial for (int i = 0; i < 2**ADDR_W; i++) mem[i] = '0;

  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr];
    for (int b = 0; b < BYTES; b++)
      if (mem_wen[b]) mem[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; fetch_req = 1'b1; fetch_addr = '0; flush = 1'b0;
    ld_req = 1'b1; ld_addr = '0; ld_wdata = '0; ld_be = 4'hF;
    ld_start = 1'b0; ld_done = 1'b0; mem_rdata = '0;
    #3;
    check("rst_fetch_gnt", fetch_gnt, 0);
    check("rst_ld_gnt", ld_gnt, 0);
    check("rst_wen", mem_wen, 0);
    check("rst_busy", boot_busy, 1);
    check("rst_rvalid", fetch_rvalid, 0);
    cyc(); cyc();
    rst = 1'b0; fetch_req = 1'b0; ld_req = 1'b0;
    #1 check("post_rst_rvalid", fetch_rvalid, 0);

    // boot load of three NOPs while fetch is asking
    for (int a = 0; a < 3; a++) begin
      fetch_req = 1'b1; fetch_addr = ADDR_W'(a);
      ld_req = 1'b1; ld_addr = ADDR_W'(a); ld_wdata = 32'h0000_0013; ld_be = 4'hF;
      #1;
      check($sformatf("boot_ld_gnt%0d", a), ld_gnt, 1);
      check($sformatf("boot_fetch_gnt%0d", a), fetch_gnt, 0);
      check($sformatf("boot_wen%0d", a), mem_wen, 4'hF);
      cyc();
    end
    // partial-byte write in the done cycle still lands
    ld_addr = 3; ld_wdata = 32'hAABB_CCDD; ld_be = 4'b0010; ld_done = 1'b1;
    #1;
    check("done_ld_gnt", ld_gnt, 1);
    check("done_busy", boot_busy, 1);
    check("done_wen", mem_wen, 4'b0010);
    cyc();
    ld_req = 1'b0; ld_done = 1'b0; fetch_req = 1'b0;
    #1 check("run_busy", boot_busy, 0);

    fetch_req = 1'b1; fetch_addr = 1;
    #1;
    check("f1_gnt", fetch_gnt, 1);
    check("f1_addr", mem_addr, 1);
    check("f1_wen", mem_wen, 0);
    cyc();
    fetch_addr = 3;
    #1;
    check("f1_rvalid", fetch_rvalid, 1);
    check("f1_rdata", fetch_rdata, 32'h0000_0013);
    cyc();
    fetch_req = 1'b0;
    #1;
    check("be_rvalid", fetch_rvalid, 1);
    check("be_rdata", fetch_rdata, 32'h0000_CC00);
    cyc();
    #1 check("idle_rvalid", fetch_rvalid, 0);

    // loader alone in RUN
    ld_req = 1'b1; ld_addr = 5; ld_wdata = 32'h1234_5678; ld_be = 4'hF;
    #1 check("run_ld_alone", ld_gnt, 1);
    cyc();

    // contention: loader forced through every fifth cycle
    fetch_req = 1'b1; fetch_addr = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      check($sformatf("cont_fetch%0d", i), fetch_gnt, (i % 5 != 4));
      check($sformatf("cont_ld%0d", i), ld_gnt, (i % 5 == 4));
      cyc();
    end
    ld_req = 1'b0; fetch_req = 1'b0;

    // flush: fire at N, flush at N+1 (with a fetch fired under flush), clean fetch at N+2
    fetch_req = 1'b1; fetch_addr = 1;
    cyc();
    flush = 1'b1; fetch_addr = 2;
    #1;
    check("fl_rvalid", fetch_rvalid, 0);
    check("fl_rdata", fetch_rdata, 0);
    check("fl_gnt", fetch_gnt, 1);
    cyc();
    flush = 1'b0; fetch_addr = 0;
    #1;
    check("fl_next_rvalid", fetch_rvalid, 0);
    check("fl_next_gnt", fetch_gnt, 1);
    cyc();
    fetch_req = 1'b0;
    #1;
    check("fl_clean_rvalid", fetch_rvalid, 1);
    check("fl_clean_rdata", fetch_rdata, 32'h0000_0013);
    cyc();

    // reload: fetch and ld_start together, then DRAIN, then BOOT
    fetch_req = 1'b1; fetch_addr = 2; ld_start = 1'b1;
    #1;
    check("rl_fetch_gnt", fetch_gnt, 1);
    check("rl_busy", boot_busy, 0);
    cyc();
    ld_start = 1'b0; ld_req = 1'b1; ld_addr = 7; ld_be = 4'hF;
    #1;
    check("dr_rvalid", fetch_rvalid, 1);
    check("dr_rdata", fetch_rdata, 32'h0000_0013);
    check("dr_fetch_gnt", fetch_gnt, 0);
    check("dr_ld_gnt", ld_gnt, 0);
    check("dr_busy", boot_busy, 1);
    check("dr_wen", mem_wen, 0);
    cyc();
    #1;
    check("bt_ld_gnt", ld_gnt, 1);
    check("bt_fetch_gnt", fetch_gnt, 0);
    check("bt_busy", boot_busy, 1);
    check("bt_rvalid", fetch_rvalid, 0);

    // back to RUN, fire a fetch, then reset before its response
    ld_req = 1'b0; ld_done = 1'b1;
    cyc();
    ld_done = 1'b0; fetch_addr = 1;
    #1 check("r2_gnt", fetch_gnt, 1);
    cyc();
    rst = 1'b1;
    #1;
    check("mrst_rvalid", fetch_rvalid, 0);
    check("mrst_fetch_gnt", fetch_gnt, 0);
    check("mrst_busy", boot_busy, 1);
    check("mrst_wen", mem_wen, 0);
    cyc();
    rst = 1'b0;
    #1;
    check("mrst_after_rvalid", fetch_rvalid, 0);
    check("mrst_after_fetch_gnt", fetch_gnt, 0);
    check("mrst_after_busy", boot_busy, 1);
    cyc();
    #1 check("mrst_after2_rvalid", fetch_rvalid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
